// File: rtl/rr_sel_arbiter_pkg.sv
// rr_sel_arbiter_pkg: shared types and sizes for the round-robin 4:1 select arbiter
package rr_sel_arbiter_pkg;
  localparam int N_REQ = 4;
  localparam int SEL_W = 4;
  localparam int PTR_W = 2;
  typedef enum logic {IDLE, GRANT} state_t;
  function automatic logic [N_REQ-1:0] onehot(input logic [PTR_W-1:0] i);
    onehot = N_REQ'(1) << i;
  endfunction
endpackage

// File: rtl/rr_sel_arbiter_pick.sv
// rr_pick: combinational round-robin search; req -> first asserted index from ptr, plus found flag
module rr_pick
  import rr_sel_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [PTR_W-1:0] idx,
  output logic             found
);
  logic [PTR_W-1:0] c;
  always_comb begin
    idx = '0;
    found = 1'b0;
    c = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      c = ptr + PTR_W'(k);
      if (req[c]) begin
        idx = c;
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/rr_sel_arbiter.sv
// rr_sel_arbiter: round-robin arbiter driving a 4:1 select; ports clk, rst, req[3:0], done -> sel[3:0], grant[3:0], busy
module rr_sel_arbiter
  import rr_sel_arbiter_pkg::*;
#(
  parameter int HOLD_MAX = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [SEL_W-1:0] sel,
  output logic [N_REQ-1:0] grant,
  output logic             busy
);
  state_t           state, state_n;
  logic [PTR_W-1:0] ptr, ptr_n, idx;
  logic [3:0]       cnt, cnt_n;
  logic [SEL_W-1:0] sel_n;
  logic             found, rel;
  rr_pick u_pick (.req(req), .ptr(ptr), .idx(idx), .found(found));
  always_comb begin
    state_n = state;
    ptr_n = ptr;
    cnt_n = cnt;
    sel_n = sel;
    rel = done || !req[sel[PTR_W-1:0]] || cnt == 4'(HOLD_MAX - 1);
    if (state == IDLE) begin
      if (found) begin
        state_n = GRANT;
        sel_n = {{(SEL_W - PTR_W){1'b0}}, idx};
        cnt_n = '0;
      end
    end else if (rel) begin
      // sel keeps the last owner so the downstream mux does not glitch
      state_n = IDLE;
      ptr_n = sel[PTR_W-1:0] + PTR_W'(1);
      cnt_n = '0;
    end else begin
      cnt_n = cnt + 4'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      cnt <= '0;
      sel <= '0;
      grant <= '0;
      busy <= 1'b0;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      cnt <= cnt_n;
      sel <= sel_n;
      grant <= state_n == GRANT ? onehot(sel_n[PTR_W-1:0]) : '0;
      busy <= state_n == GRANT;
    end
  end
endmodule
